// File: rtl/snake_engine.sv
// Multi-segment snake engine: circular body buffer, tick-driven move FSM and registered grid renderer.
// Optional build macro SNAKE_ENGINE_BORDER_WALL_EN makes grid edges lethal and draws the outer cell ring.

module snake_engine #(
    parameter int GRID_W    = 80,
    parameter int GRID_H    = 60,
    parameter int CELL_LOG2 = 3,
    parameter int MAX_LEN   = 32,
    parameter int INIT_LEN  = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       GAME_TICK,
    input  logic [1:0] DIRECTION,
    input  logic [9:0] ADDRH,
    input  logic [8:0] ADDRV,
    input  logic [6:0] RAND_H,
    input  logic [5:0] RAND_V,
    output logic [7:0] COLOUR,
    output logic       REACHED_TARGET,
    output logic       GAME_OVER,
    output logic [6:0] LENGTH,
    output logic       BUSY
);

    localparam int PW = $clog2(MAX_LEN);

    typedef enum logic [2:0] {ST_IDLE, ST_MOVE, ST_SCAN, ST_COMMIT, ST_DEAD} state_t;

    state_t        state_r, state_next_s;
    logic [12:0]   body_r [MAX_LEN];
    logic [PW-1:0] head_ptr_r, new_ptr_s, scan_addr_s, rel_s;
    logic [1:0]    heading_r, eff_dir_s;
    logic [6:0]    apple_h_r, length_r, scan_idx_r, scan_last_s, nh_h_s, head_h_s;
    logic [5:0]    apple_v_r, nh_v_s, head_v_s;
    logic [12:0]   next_head_r, head_s, cell_s;
    logic          eat_r, seg_hit_s;
    logic          busy_s, game_over_s, reached_s;
    logic          busy_r, game_over_r, reached_r;
    logic [9:0]    cell_h_s;
    logic [8:0]    cell_v_s;
    logic          in_grid_s, body_hit_s;
    logic [7:0]    colour_s, colour_r;

    assign head_s      = body_r[head_ptr_r];
    assign head_h_s    = head_s[6:0];
    assign head_v_s    = head_s[12:7];
    assign new_ptr_s   = head_ptr_r - PW'(1);
    assign scan_addr_s = head_ptr_r + scan_idx_r[PW-1:0];
    assign seg_hit_s   = (body_r[scan_addr_s] == next_head_r);
    assign scan_last_s = (eat_r ? length_r : length_r - 7'd1) - 7'd1;
    // Direction codes are chosen so that the exact reverse is the bitwise complement.
    assign eff_dir_s   = (DIRECTION == ~heading_r) ? heading_r : DIRECTION;

    // Candidate head position one cell along the effective heading, wrapping at grid edges.
    always_comb begin
        nh_h_s = head_h_s;
        nh_v_s = head_v_s;
        case (eff_dir_s)
            2'b00: nh_h_s = (head_h_s == 7'(GRID_W - 1)) ? 7'd0 : head_h_s + 7'd1;
            2'b11: nh_h_s = (head_h_s == 7'd0) ? 7'(GRID_W - 1) : head_h_s - 7'd1;
            2'b01: nh_v_s = (head_v_s == 6'(GRID_H - 1)) ? 6'd0 : head_v_s + 6'd1;
            2'b10: nh_v_s = (head_v_s == 6'd0) ? 6'(GRID_H - 1) : head_v_s - 6'd1;
            default: nh_h_s = head_h_s;
        endcase
    end

`ifdef SNAKE_ENGINE_BORDER_WALL_EN
    logic wall_s;

    // Moving off any grid edge is fatal when walls are enabled.
    always_comb begin
        wall_s = ((eff_dir_s == 2'b00) && (head_h_s == 7'(GRID_W - 1))) ||
                 ((eff_dir_s == 2'b11) && (head_h_s == 7'd0)) ||
                 ((eff_dir_s == 2'b01) && (head_v_s == 6'(GRID_H - 1))) ||
                 ((eff_dir_s == 2'b10) && (head_v_s == 6'd0));
    end
`endif

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) state_r <= ST_IDLE;
        else       state_r <= state_next_s;
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (GAME_TICK) state_next_s = ST_MOVE;
                else           state_next_s = ST_IDLE;
            end
            ST_MOVE: begin
`ifdef SNAKE_ENGINE_BORDER_WALL_EN
                if (wall_s) state_next_s = ST_DEAD;
                else        state_next_s = ST_SCAN;
`else
                state_next_s = ST_SCAN;
`endif
            end
            ST_SCAN: begin
                if (seg_hit_s)                       state_next_s = ST_DEAD;
                else if (scan_idx_r == scan_last_s)  state_next_s = ST_COMMIT;
                else                                 state_next_s = ST_SCAN;
            end
            ST_COMMIT: state_next_s = ST_IDLE;
            ST_DEAD:   state_next_s = ST_DEAD;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode, taken from the next state so the registered flags align with the state.
    always_comb begin
        busy_s      = (state_next_s == ST_MOVE) || (state_next_s == ST_SCAN) ||
                      (state_next_s == ST_COMMIT);
        game_over_s = (state_next_s == ST_DEAD);
        reached_s   = (state_next_s == ST_COMMIT) && eat_r;
    end

    // Output flag registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            busy_r      <= 1'b0;
            game_over_r <= 1'b0;
            reached_r   <= 1'b0;
        end else begin
            busy_r      <= busy_s;
            game_over_r <= game_over_s;
            reached_r   <= reached_s;
        end
    end

    // Body buffer, heading, apple and length updates driven by the move sequence.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            head_ptr_r  <= '0;
            for (int i = 0; i < MAX_LEN; i++)
                body_r[i] <= (i < INIT_LEN) ? {6'(GRID_H / 2), 7'(GRID_W / 2 - i)} : 13'd0;
            heading_r   <= 2'b00;
            apple_h_r   <= 7'(GRID_W / 4);
            apple_v_r   <= 6'(GRID_H / 4);
            length_r    <= 7'(INIT_LEN);
            scan_idx_r  <= 7'd0;
            next_head_r <= 13'd0;
            eat_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_MOVE: begin
                    heading_r   <= eff_dir_s;
                    next_head_r <= {nh_v_s, nh_h_s};
                    eat_r       <= ({nh_v_s, nh_h_s} == {apple_v_r, apple_h_r});
                    scan_idx_r  <= 7'd0;
                end
                ST_SCAN: scan_idx_r <= scan_idx_r + 7'd1;
                ST_COMMIT: begin
                    head_ptr_r        <= new_ptr_s;
                    body_r[new_ptr_s] <= next_head_r;
                    if (eat_r) begin
                        if (length_r < 7'(MAX_LEN)) length_r <= length_r + 7'd1;
                        apple_h_r <= ({1'b0, RAND_H} < 8'(GRID_W)) ? RAND_H : 7'(GRID_W / 2);
                        apple_v_r <= ({1'b0, RAND_V} < 7'(GRID_H)) ? RAND_V : 6'(GRID_H / 2);
                    end
                end
                default: scan_idx_r <= scan_idx_r;
            endcase
        end
    end

    assign cell_h_s  = ADDRH >> CELL_LOG2;
    assign cell_v_s  = ADDRV >> CELL_LOG2;
    assign in_grid_s = (cell_h_s < 10'(GRID_W)) && (cell_v_s < 9'(GRID_H));
    assign cell_s    = {cell_v_s[5:0], cell_h_s[6:0]};

    // Parallel body hit: a buffer slot is live when its distance from the head is below LENGTH.
    always_comb begin
        body_hit_s = 1'b0;
        rel_s      = '0;
        for (int j = 0; j < MAX_LEN; j++) begin
            rel_s      = PW'(j) - head_ptr_r;
            body_hit_s = body_hit_s |
                         (({{(7 - PW){1'b0}}, rel_s} < length_r) && (body_r[j] == cell_s));
        end
    end

    // Pixel colour priority: off-grid, apple, head, body, border ring, background.
    always_comb begin
        if (!in_grid_s)                             colour_s = 8'h00;
        else if (cell_s == {apple_v_r, apple_h_r})  colour_s = 8'h07;
        else if (cell_s == head_s)                  colour_s = (state_r == ST_DEAD) ? 8'hC0 : 8'hFF;
        else if (body_hit_s)                        colour_s = 8'hF8;
`ifdef SNAKE_ENGINE_BORDER_WALL_EN
        else if ((cell_h_s == 10'd0) || (cell_h_s == 10'(GRID_W - 1)) ||
                 (cell_v_s == 9'd0) || (cell_v_s == 9'(GRID_H - 1)))
                                                    colour_s = 8'h38;
`endif
        else                                        colour_s = 8'h40;
    end

    // Registered pixel colour.
    always_ff @(posedge CLK) begin
        if (RESET) colour_r <= 8'h00;
        else       colour_r <= colour_s;
    end

    assign COLOUR         = colour_r;
    assign REACHED_TARGET = reached_r;
    assign GAME_OVER      = game_over_r;
    assign BUSY           = busy_r;
    assign LENGTH         = length_r;

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: directed sequence plus random ticks against a queue-based game model.
module tb_snake_engine;

    localparam int W = 80, H = 60, ML = 32, IL = 4;

    logic       CLK = 1'b0;
    logic       RESET, GAME_TICK;
    logic [1:0] DIRECTION;
    logic [9:0] ADDRH;
    logic [8:0] ADDRV;
    logic [6:0] RAND_H;
    logic [5:0] RAND_V;
    logic [7:0] COLOUR;
    logic       REACHED_TARGET, GAME_OVER, BUSY;
    logic [6:0] LENGTH;

    int total = 0, bad = 0, reach_cycles = 0;

    // Game model: body as queues of cell coordinates, index 0 = head.
    int bh[$], bv[$];
    int hdx, hdy, ah, av;
    bit dead;

    snake_engine #(.GRID_W(W), .GRID_H(H), .CELL_LOG2(3), .MAX_LEN(ML), .INIT_LEN(IL)) dut (
        .CLK(CLK), .RESET(RESET), .GAME_TICK(GAME_TICK), .DIRECTION(DIRECTION),
        .ADDRH(ADDRH), .ADDRV(ADDRV), .RAND_H(RAND_H), .RAND_V(RAND_V),
        .COLOUR(COLOUR), .REACHED_TARGET(REACHED_TARGET), .GAME_OVER(GAME_OVER),
        .LENGTH(LENGTH), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (REACHED_TARGET === 1'b1) reach_cycles++;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void dir_vec(input int d, output int dx, output int dy);
        case (d)
            0: begin dx = 1;  dy = 0;  end
            1: begin dx = 0;  dy = 1;  end
            2: begin dx = 0;  dy = -1; end
            default: begin dx = -1; dy = 0; end
        endcase
    endfunction

    function automatic logic [7:0] model_colour(input int px, input int py);
        int ch, cv;
        ch = px / 8;
        cv = py / 8;
        if (ch >= W || cv >= H) return 8'h00;
        if (ch == ah && cv == av) return 8'h07;
        if (ch == bh[0] && cv == bv[0]) return dead ? 8'hC0 : 8'hFF;
        foreach (bh[i]) if (bh[i] == ch && bv[i] == cv) return 8'hF8;
`ifdef SNAKE_ENGINE_BORDER_WALL_EN
        if (ch == 0 || ch == W - 1 || cv == 0 || cv == H - 1) return 8'h38;
`endif
        return 8'h40;
    endfunction

    task automatic model_reset();
        bh = {};
        bv = {};
        for (int i = 0; i < IL; i++) begin
            bh.push_back(W / 2 - i);
            bv.push_back(H / 2);
        end
        hdx = 1; hdy = 0; ah = W / 4; av = H / 4; dead = 0;
    endtask

    // One move per the game rules; returns the expected BUSY cycle count and whether an apple was eaten.
    task automatic model_tick(input int dir, input int rh, input int rv,
                              output int exp_busy, output bit ate);
        int dx, dy, nh, nv, n, k;
        bit eat;
        ate = 0;
        exp_busy = 0;
        if (dead) return;
        dir_vec(dir, dx, dy);
        if (dx + hdx == 0 && dy + hdy == 0) begin dx = hdx; dy = hdy; end
        hdx = dx; hdy = dy;
        nh = bh[0] + dx;
        nv = bv[0] + dy;
`ifdef SNAKE_ENGINE_BORDER_WALL_EN
        if (nh < 0 || nh >= W || nv < 0 || nv >= H) begin
            dead = 1; exp_busy = 1; return;
        end
`endif
        nh = (nh + W) % W;
        nv = (nv + H) % H;
        eat = (nh == ah && nv == av);
        n = eat ? bh.size() : bh.size() - 1;
        k = -1;
        for (int i = 0; i < n; i++)
            if (k < 0 && bh[i] == nh && bv[i] == nv) k = i;
        if (k >= 0) begin
            dead = 1; exp_busy = k + 2; return;
        end
        bh.push_front(nh);
        bv.push_front(nv);
        if (!eat || bh.size() > ML) begin
            void'(bh.pop_back());
            void'(bv.pop_back());
        end
        if (eat) begin
            ah = (rh < W) ? rh : W / 2;
            av = (rv < H) ? rv : H / 2;
        end
        exp_busy = n + 2;
        ate = eat;
    endtask

    task automatic read_pix(input int px, input int py, output logic [7:0] c);
        ADDRH = px[9:0];
        ADDRV = py[8:0];
        @(posedge CLK); #1;
        c = COLOUR;
    endtask

    task automatic check_pix(input string tag, input int px, input int py);
        logic [7:0] c, e;
        e = model_colour(px, py);
        read_pix(px, py, c);
        chk(tag, c, e);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        GAME_TICK = 1'b0;
        @(posedge CLK); #1;
        chk("rst_colour", COLOUR, 8'h00);
        chk("rst_length", LENGTH, 7'(IL));
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_game_over", GAME_OVER, 1'b0);
        chk("rst_reached", REACHED_TARGET, 1'b0);
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic do_tick(input int dir, input int rh, input int rv, input int hold);
        int cnt, el, exp_busy, r0;
        bit ate;
        r0 = reach_cycles;
        DIRECTION = dir[1:0];
        RAND_H = rh[6:0];
        RAND_V = rv[5:0];
        GAME_TICK = 1'b1;
        @(posedge CLK); #1;
        cnt = 0;
        el = 1;
        while (BUSY === 1'b1 && cnt < 300) begin
            cnt++;
            GAME_TICK = (el < hold);
            el++;
            @(posedge CLK); #1;
        end
        GAME_TICK = 1'b0;
        model_tick(dir, rh, rv, exp_busy, ate);
        chk("busy_cycles", cnt, exp_busy);
        chk("length", LENGTH, bh.size());
        chk("game_over", GAME_OVER, dead);
        chk("reached_cycles", reach_cycles - r0, ate);
        check_pix("head_pix", bh[0] * 8 + $urandom_range(0, 7), bv[0] * 8 + $urandom_range(0, 7));
        check_pix("tail_pix", bh[bh.size() - 1] * 8 + $urandom_range(0, 7),
                  bv[bv.size() - 1] * 8 + $urandom_range(0, 7));
        check_pix("rand_pix", $urandom_range(0, 719), $urandom_range(0, 511));
    endtask

    initial begin
        logic [7:0] c;
        RESET = 1'b1; GAME_TICK = 1'b0; DIRECTION = 2'b00;
        ADDRH = 10'd0; ADDRV = 9'd0; RAND_H = 7'd0; RAND_V = 6'd0;
        @(posedge CLK); #1;
        do_reset();
        read_pix(323, 243, c);
        chk("reset_head_pixel", c, 8'hFF);
        check_pix("reset_tail", 37 * 8, 30 * 8);

        repeat (3) do_tick(0, 0, 0, 1);
        read_pix(43 * 8 + 2, 30 * 8 + 5, c);
        chk("head_43_30", c, 8'hFF);
        read_pix(40 * 8, 30 * 8, c);
        chk("tail_40_30", c, 8'hF8);
        chk("no_apple_yet", reach_cycles, 0);

        do_tick(3, 0, 0, 1);
        read_pix(44 * 8, 30 * 8, c);
        chk("reverse_ignored", c, 8'hFF);

        repeat (15) do_tick(2, 0, 0, 1);
        repeat (23) do_tick(3, 0, 0, 1);
        do_tick(3, 100, 10, 1);
        chk("len_after_eat", LENGTH, 7'd5);
        read_pix(40 * 8 + 3, 10 * 8 + 3, c);
        chk("apple_relocated", c, 8'h07);

        do_tick(2, 0, 0, 1);
        do_tick(0, 0, 0, 1);
        do_tick(1, 0, 0, 1);
        chk("self_collision", GAME_OVER, 1'b1);
        read_pix(21 * 8, 14 * 8, c);
        chk("dead_head_pixel", c, 8'hC0);
        repeat (3) do_tick($urandom_range(0, 3), 0, 0, 1);

        do_reset();
        read_pix(323, 243, c);
        chk("reset_after_dead", c, 8'hFF);

        do_tick(0, 0, 0, 3);
        read_pix(41 * 8, 30 * 8, c);
        chk("double_tick_one_move", c, 8'hFF);
        read_pix(37 * 8, 30 * 8, c);
        chk("double_tick_tail_gone", c, 8'h40);

        GAME_TICK = 1'b1;
        @(posedge CLK); #1;
        GAME_TICK = 1'b0;
        @(posedge CLK); #1;
        do_reset();
        check_pix("abort_head", 40 * 8, 30 * 8);
        check_pix("abort_next", 41 * 8, 30 * 8);

        // Grow to saturation by planting each new apple directly in the path.
        repeat (15) do_tick(2, 0, 0, 1);
        repeat (19) do_tick(3, 0, 0, 1);
        for (int i = 0; i < 40; i++) do_tick(3, (bh[0] - 2 + W) % W, 15, 1);
        chk("length_saturated", LENGTH, 7'(ML));

        do_reset();
        repeat (40) do_tick(0, 0, 0, 1);

        for (int i = 0; i < 120; i++) begin
            if (dead && $urandom_range(0, 2) == 0) do_reset();
            do_tick($urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 63),
                    $urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
